// File: rtl/mux_pkg.sv
// Shared definitions for the mux family: mode encoding and select-width helper.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Select width for an n-way mux; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Auto-scan channel counter: wraps NCH-1 -> 0, clear has priority over increment.
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int unsigned NCH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [sel_width(NCH)-1:0] cnt
);

  localparam int unsigned SW = sel_width(NCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == SW'(NCH - 1)) ? '0 : cnt + SW'(1);
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered channel mux with direct/auto-scan select, all-ones override and
// a single-entry valid/ready output stage.
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter int unsigned NCH = 16,
  parameter int unsigned W   = 1,
  parameter int unsigned SW  = sel_width(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] in_data,
  input  logic [SW-1:0]    sel,
  input  logic             mode,
  input  logic             force_ones,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_ch,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SW-1:0] cnt;
  logic [SW-1:0] ch;
  logic [W-1:0]  mux_data;
  logic          ch_hit;
  logic          accept;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign ch       = (mode == MODE_SCAN) ? cnt : sel;

  mux_scan_ctr #(
    .NCH (NCH)
  ) u_scan_ctr (
    .clk (clk),
    .rst (rst),
    .clr (mode == MODE_DIRECT),
    .inc (accept & (mode == MODE_SCAN)),
    .cnt (cnt)
  );

  // Decoded mux; an index with no matching channel yields zero and no hit.
  always_comb begin
    mux_data = '0;
    ch_hit   = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (ch == SW'(c)) begin
        mux_data = in_data[c*W +: W];
        ch_hit   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= force_ones ? '1 : mux_data;
      out_ch    <= ch;
      out_err   <= ~ch_hit & ~force_ones;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: a 16x1 and a 12x4 instance driven in lockstep and
// compared against an arithmetic reference model.
module tb_mux_sel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic        mode, force_ones, in_valid, out_ready;
  logic [15:0] d16;
  logic [47:0] d12;

  logic        rdy16, ov16, oe16;
  logic [0:0]  od16;
  logic [3:0]  oc16;
  logic        rdy12, ov12, oe12;
  logic [3:0]  od12;
  logic [3:0]  oc12;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          mv;
  int unsigned s16, s12;
  int unsigned md16, md12, mc16, mc12;
  bit          me16, me12;

  always #5 clk = ~clk;

  mux_sel_pipe #(.NCH(16), .W(1)) dut16 (
    .clk(clk), .rst(rst), .in_data(d16), .sel(sel), .mode(mode),
    .force_ones(force_ones), .in_valid(in_valid), .in_ready(rdy16),
    .out_data(od16), .out_ch(oc16), .out_err(oe16), .out_valid(ov16),
    .out_ready(out_ready)
  );

  mux_sel_pipe #(.NCH(12), .W(4)) dut12 (
    .clk(clk), .rst(rst), .in_data(d12), .sel(sel), .mode(mode),
    .force_ones(force_ones), .in_valid(in_valid), .in_ready(rdy12),
    .out_data(od12), .out_ch(oc12), .out_err(oe12), .out_valid(ov12),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv = 0; s16 = 0; s12 = 0;
    md16 = 0; md12 = 0; mc16 = 0; mc12 = 0; me16 = 0; me12 = 0;
  endtask

  // One rising edge of the behavioural model, using the inputs as applied.
  task automatic model_edge();
    bit acc;
    int unsigned c16, c12;
    acc = in_valid && (!mv || out_ready);
    if (acc) begin
      c16  = mode ? s16 : int'(sel);
      c12  = mode ? s12 : int'(sel);
      mc16 = c16;
      mc12 = c12;
      md16 = force_ones ? 1 : (c16 >= 16 ? 0 : (int'(d16) >> c16) % 2);
      md12 = force_ones ? 15 : (c12 >= 12 ? 0 : int'((d12 >> (c12 * 4)) & 48'hF));
      me16 = (c16 >= 16) && !force_ones;
      me12 = (c12 >= 12) && !force_ones;
      mv   = 1;
    end else if (out_ready) begin
      mv = 0;
    end
    if (!mode) begin
      s16 = 0; s12 = 0;
    end else if (acc) begin
      s16 = (s16 + 1) % 16;
      s12 = (s12 + 1) % 12;
    end
  endtask

  task automatic check_all();
    check("rdy16", 32'(rdy16), 32'(!mv || out_ready));
    check("rdy12", 32'(rdy12), 32'(!mv || out_ready));
    check("ov16",  32'(ov16),  32'(mv));
    check("ov12",  32'(ov12),  32'(mv));
    check("od16",  32'(od16),  md16);
    check("od12",  32'(od12),  md12);
    check("oc16",  32'(oc16),  mc16);
    check("oc12",  32'(oc12),  mc12);
    check("oe16",  32'(oe16),  32'(me16));
    check("oe12",  32'(oe12),  32'(me12));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse inside the low phase of the clock.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_ov16", 32'(ov16), 32'd0);
    check("rst_ov12", 32'(ov12), 32'd0);
    check("rst_oc16", 32'(oc16), 32'd0);
    check("rst_od12", 32'(od12), 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = '0; mode = 1'b0; force_ones = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; d16 = '0; d12 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // direct select of channel 5 with only bit 5 set
    mode = 1'b0; sel = 4'd5; d16 = 16'h0020; d12 = 48'h0000_0090_0000;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    check("r034_data", 32'(od16), 32'd1);
    check("r034_ch",   32'(oc16), 32'd5);
    check("r034_ov",   32'(ov16), 32'd1);
    check("r034_d12",  32'(od12), 32'd9);

    // override forces all-ones without an error flag
    force_ones = 1'b1; sel = 4'd3; d16 = '0; d12 = '0;
    cyc();
    check("r035_d12", 32'(od12), 32'hF);
    check("r035_ch",  32'(oc12), 32'd3);
    check("r035_err", 32'(oe12), 32'd0);
    force_ones = 1'b0;

    // out-of-range index on the 12-channel instance
    sel = 4'd14; d12 = 48'hFFFF_FFFF_FFFF; d16 = 16'h4000;
    cyc();
    check("r037_d12", 32'(od12), 32'd0);
    check("r037_err", 32'(oe12), 32'd1);
    check("r037_ch",  32'(oc12), 32'd14);
    check("r037_d16", 32'(od16), 32'd1);

    // auto-scan over 18 continuous accepts
    mode = 1'b1; d16 = 16'hA5C3; d12 = 48'h0123_4567_89AB;
    for (int i = 0; i < 18; i++) begin
      cyc();
      check("r036_seq", 32'(oc16), 32'(i % 16));
    end

    // backpressure: outputs frozen, ready low, then drain with new accept
    mode = 1'b0; sel = 4'd9; cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 4'($urandom); d16 = 16'($urandom); force_ones = 1'($urandom);
      cyc();
      check("r038_hold_ch", 32'(oc16), 32'd9);
      check("r038_rdy",     32'(rdy16), 32'd0);
    end
    force_ones = 1'b0; sel = 4'd2; out_ready = 1'b1;
    cyc();
    check("r038_new_ch", 32'(oc16), 32'd2);
    check("r038_ov",     32'(ov16), 32'd1);

    // reset mid-transfer at scan count 7
    mode = 1'b0; cyc();
    mode = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    check("r039_pre_ov", 32'(ov16), 32'd1);
    pulse_rst();
    cyc();
    check("r039_ch0", 32'(oc16), 32'd0);
    check("r039_ch0_12", 32'(oc12), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel        = 4'($urandom);
      d16        = 16'($urandom);
      d12        = {16'($urandom), 32'($urandom)};
      mode       = ($urandom_range(0, 2) != 0);
      force_ones = ($urandom_range(0, 7) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) pulse_rst();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_sel_pipe.md
MUX_SEL_PIPE -- requirements
Module: mux_sel_pipe

Interface
REQ-001 Parameter NCH, default 16: number of input channels, 2..64.
REQ-002 Parameter W, default 1: bits per channel, 1..32.
REQ-003 Parameter SW, default $clog2(NCH): select width, derived, not overridden.
REQ-004 The clock is clk, one clock domain; reset is rst, asynchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_data  in  NCH*W  channel c occupies bits [c*W +: W].
REQ-008 sel  in  SW  channel select, used when mode=0.
REQ-009 mode  in  1  0 = direct select, 1 = auto-scan.
REQ-010 force  in  1  override; selected output becomes all-ones.
REQ-011 in_valid  in  1  request to sample the mux.
REQ-012 in_ready  out  1  sample accepted this cycle when in_valid & in_ready.
REQ-013 out_data  out  W  registered mux result.
REQ-014 out_ch  out  SW  channel index that produced out_data.
REQ-015 out_err  out  1  set with out_data when the selected index was >= NCH.
REQ-016 out_valid  out  1  out_data/out_ch/out_err hold a result.
REQ-017 out_ready  in  1  consumer accepts the result when out_valid & out_ready.

Function
REQ-018 Effective channel ch SHALL be sel when mode=0 and the scan counter value when mode=1.
REQ-019 On accept, the block SHALL register out_data = all-ones if force, else zero if ch >= NCH, else in_data[ch*W +: W].
REQ-020 On accept, out_ch SHALL register ch and out_err SHALL register (ch >= NCH) & ~force.
REQ-021 Latency SHALL be exactly one cycle from accept to out_valid=1.
REQ-022 in_ready SHALL equal ~out_valid | out_ready (single output register, combinational ready).
REQ-023 out_valid SHALL set on accept, clear on out_ready with no accept, and stay 1 on simultaneous accept and drain, with the new result replacing the old one.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_ch, out_err SHALL be held stable.
REQ-025 The scan counter SHALL advance by one on each accept while mode=1 and wrap from NCH-1 to 0.
REQ-026 The scan counter SHALL be cleared to 0 in any cycle with mode=0; the first accept after mode goes 0->1 SHALL sample channel 0.
REQ-027 force SHALL NOT suppress scan counter advance.
REQ-028 Inputs SHALL be sampled only on accept; changes to sel/mode/force at other times SHALL have no effect on outputs.

Reset
REQ-029 Asserting rst SHALL immediately clear out_valid, out_data, out_ch, out_err, and the scan counter to 0, including mid-transfer.
REQ-030 After rst deasserts, in_ready SHALL be 1 and the first accept SHALL behave as for a fresh block.

Structure
REQ-031 Package mux_pkg SHALL hold the mode encoding constants (MODE_DIRECT=0, MODE_SCAN=1) and a select-width function shared with other mux blocks.
REQ-032 The scan counter SHALL be one sub-module, mux_scan_ctr (parameter NCH; ports clk, rst, clr, inc, cnt).
REQ-033 RTL SHALL be synthesizable and free of latches.

Verification
REQ-034 NCH=16, W=1, mode=0, sel=5, in_data bit5=1, others 0, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=1, out_ch=5, out_err=0.
REQ-035 force=1, sel=3, in_data=0 -> out_data=all-ones, out_ch=3, out_err=0.
REQ-036 mode=1, continuous accepts for 18 cycles -> out_ch sequence 0..15,0,1.
REQ-037 NCH=12, sel=14 -> out_data=0, out_err=1, out_ch=14.
REQ-038 out_ready=0 for 4 cycles after a result -> in_ready=0, outputs held; out_ready=1 with in_valid=1 -> new result next cycle, out_valid never drops.
REQ-039 rst pulsed while out_valid=1 in scan mode at count 7 -> out_valid=0 immediately; next accept samples channel 0.
